// File: rtl/calc_params_pkg.sv
// calc_params_pkg
//   Shared types and timing constants for the multi-axis profile calculator.
//   calc_state_t : controller states (one pass of DIV_NN..STORE per axis)
//   calc_mode_t  : FULL (move long enough for a cruise phase) or SHORT
//   axis_cyc()   : cycles spent per axis for a divider of width tw
package calc_params_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV_NN,
        DIV_TNA,
        DIV_T0,
        DIV_DLT,
        STORE,
        DONE
    } calc_state_t;

    typedef enum logic {
        FULL,
        SHORT
    } calc_mode_t;

    // Each divide state lasts tw+2 cycles (issue cycle + tw+1 to done),
    // four divides per axis plus one STORE cycle.
    function automatic int axis_cyc(input int tw);
        return 4 * (tw + 2) + 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider
//   Restoring radix-2 unsigned divider, one quotient bit per cycle.
//   Latency is fixed: done pulses exactly TW+1 cycles after start.
//   Divide-by-zero yields an all-ones quotient.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             load operands and begin (restarts any divide in flight)
//   dividend, divisor TW-bit operands, sampled on start
//   quotient          TW-bit result, valid when done is high
//   done              one-cycle completion pulse
module seq_divider #(
    parameter int TW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [TW-1:0] dividend,
    input  logic [TW-1:0] divisor,
    output logic [TW-1:0] quotient,
    output logic          done
);

    localparam int CW = $clog2(TW + 1);

    logic [TW-1:0] rem_q;
    logic [TW-1:0] quo_q;
    logic [TW-1:0] dvs_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    logic [TW:0]   shl;
    logic          ge;

    // Dividend bits are shifted out of the top of quo_q while quotient
    // bits are shifted in at the bottom.
    always_comb begin
        shl = {rem_q, quo_q[TW-1]};
        ge  = (shl >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= CW'(TW);
            end else if (cnt_q != '0) begin
                // Remainder stays below the divisor, so TW bits suffice.
                rem_q  <= TW'(ge ? (shl - {1'b0, dvs_q}) : shl);
                quo_q  <= {quo_q[TW-2:0], ge};
                cnt_q  <= cnt_q - CW'(1);
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_profile_params_multi.sv
// calc_profile_params_multi
//   Computes the accel/decel profile {nn, t0, tna, delta} for NUM_AXES step
//   counts using one shared sequential divider. Every state runs its full
//   length regardless of data, so start->done is always
//   2 + NUM_AXES*axis_cyc(TW) cycles.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start                      request, accepted only while idle
//   steps                      per-axis N, axis a at [a*W +: W]
//   max_n, max_nn              reference move length and its accel steps
//   max_tna, max_delta         cruise period limit, reference decrement
//   t1, t2, tt                 accel-phase time, cruise time, single-step time
//   busy                       high while a request is in progress
//   done                       one-cycle pulse when all axes are stored
//   nn_o, t0_o, tna_o, delta_o per-axis results, packed like steps
//   sat                        per-axis delta clamp flag
// Build option
//   CALC_CLAMP_EN : clamp delta to max_delta and report it on sat;
//                   otherwise delta is raw and sat is 0.
import calc_params_pkg::*;

module calc_profile_params_multi #(
    parameter int NUM_AXES = 4,
    parameter int W        = 32,
    parameter int TW       = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_AXES*W-1:0] steps,
    input  logic [W-1:0]          max_n,
    input  logic [W-1:0]          max_nn,
    input  logic [W-1:0]          max_tna,
    input  logic [W-1:0]          max_delta,
    input  logic [TW-1:0]         t1,
    input  logic [TW-1:0]         t2,
    input  logic [TW-1:0]         tt,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_AXES*W-1:0] nn_o,
    output logic [NUM_AXES*W-1:0] t0_o,
    output logic [NUM_AXES*W-1:0] tna_o,
    output logic [NUM_AXES*W-1:0] delta_o,
    output logic [NUM_AXES-1:0]   sat
);

    localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;

    function automatic logic [TW-1:0] sub_sat(input logic [TW-1:0] a, input logic [TW-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    calc_state_t state_q, state_d;
    calc_mode_t  mode_q;
    logic [AXW-1:0] ax_q;
    logic go_q;

    logic [NUM_AXES*W-1:0] steps_q;
    logic [W-1:0]  max_n_q, max_nn_q, max_tna_q, max_delta_q;
    logic [TW-1:0] t1_q, t2_q, tt_q;
    logic [W-1:0]  nn_q, tna_q, t0_q, dlt_q;
    logic [NUM_AXES*W-1:0] nn_r, t0_r, tna_r, dl_r;

    logic [TW-1:0] div_a, div_b, div_quo;
    logic          div_done;
    logic [W-1:0]  n_cur, quo_w, nn_sel, tna_sel;
    logic [TW-1:0] n_tw, nn_tw, tna_tw, t0_tw, tna_rem, t0_prod, t0_base, tt_sh;
    logic [W-1:0]  fin_nn, fin_t0, fin_tna, fin_dl;
    logic          unused_bits;

    seq_divider #(.TW(TW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (go_q),
        .dividend (div_a),
        .divisor  (div_b),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = DIV_NN;
            DIV_NN:  if (div_done) state_d = DIV_TNA;
            DIV_TNA: if (div_done) state_d = DIV_T0;
            DIV_T0:  if (div_done) state_d = DIV_DLT;
            DIV_DLT: if (div_done) state_d = STORE;
            STORE:   state_d = (ax_q == AXW'(NUM_AXES - 1)) ? DONE : DIV_NN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: divider operands for the current state and the value each
    // divide state captures when the divider finishes.
    always_comb begin
        n_cur   = steps_q[ax_q*W +: W];
        n_tw    = TW'(n_cur);
        nn_tw   = TW'(nn_q);
        tna_tw  = TW'(tna_q);
        t0_tw   = TW'(t0_q);
        quo_w   = div_quo[W-1:0];
        nn_sel  = (mode_q == FULL) ? ((quo_w == '0) ? W'(1) : quo_w) : (n_cur >> 1);
        tna_rem = sub_sat(n_tw, nn_tw << 1);
        // A zero cruise length uses the limit; the divider result is ignored.
        tna_sel = (mode_q == SHORT || tna_rem == '0) ? max_tna_q : quo_w;
        t0_prod = tna_tw * sub_sat(nn_tw, TW'(1));
        t0_base = (mode_q == FULL) ? (t1_q << 1) : (tt_q << 2);
        div_a   = '0;
        div_b   = '0;
        case (state_q)
            DIV_NN:  begin div_a = TW'(max_nn_q) * n_tw;         div_b = TW'(max_n_q);   end
            DIV_TNA: begin div_a = t2_q;                         div_b = tna_rem;        end
            DIV_T0:  begin div_a = sub_sat(t0_base, t0_prod);    div_b = nn_tw + TW'(1); end
            DIV_DLT: begin div_a = sub_sat(t0_tw, tna_tw);       div_b = nn_tw;          end
            default: ;
        endcase
    end

    // Final per-axis selection: small N overrides the computed chain.
    always_comb begin
        tt_sh   = (mode_q == FULL) ? (tt_q >> 1) : (tt_q << 1);
        fin_nn  = nn_q;
        fin_t0  = t0_q;
        fin_tna = tna_q;
        fin_dl  = dlt_q;
        if (n_cur == '0) begin
            fin_nn = '0; fin_t0 = '0; fin_tna = '0; fin_dl = '0;
        end else if (n_cur == W'(1)) begin
            fin_nn = W'(1); fin_t0 = tt_q[W-1:0]; fin_tna = max_tna_q; fin_dl = max_delta_q;
        end else if (n_cur == W'(2)) begin
            fin_nn = W'(1); fin_t0 = tt_sh[W-1:0]; fin_tna = max_tna_q; fin_dl = '0;
        end
    end

    assign unused_bits = ^{div_quo, tt_sh};

`ifdef CALC_CLAMP_EN
    logic [NUM_AXES-1:0] sat_q;
    logic [W-1:0]        out_dl;
    logic                clamp;
    always_comb begin
        clamp  = (fin_dl > max_delta_q);
        out_dl = clamp ? max_delta_q : fin_dl;
    end
    assign sat = sat_q;
`else
    logic [W-1:0] out_dl;
    assign out_dl = fin_dl;
    assign sat    = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= FULL;
            ax_q        <= '0;
            go_q        <= 1'b0;
            steps_q     <= '0;
            max_n_q     <= '0;
            max_nn_q    <= '0;
            max_tna_q   <= '0;
            max_delta_q <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            tt_q        <= '0;
            nn_q        <= '0;
            tna_q       <= '0;
            t0_q        <= '0;
            dlt_q       <= '0;
            nn_r        <= '0;
            t0_r        <= '0;
            tna_r       <= '0;
            dl_r        <= '0;
`ifdef CALC_CLAMP_EN
            sat_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Kick the divider on the first cycle of every divide state.
            go_q <= (state_d inside {DIV_NN, DIV_TNA, DIV_T0, DIV_DLT}) && (state_d != state_q);
            case (state_q)
                IDLE: if (start) begin
                    steps_q     <= steps;
                    max_n_q     <= max_n;
                    max_nn_q    <= max_nn;
                    max_tna_q   <= max_tna;
                    max_delta_q <= max_delta;
                    t1_q        <= t1;
                    t2_q        <= t2;
                    tt_q        <= tt;
                    ax_q        <= '0;
                end
                LOAD:    mode_q <= (TW'(max_n_q) >= ((TW'(max_nn_q) << 1) + TW'(2))) ? FULL : SHORT;
                DIV_NN:  if (div_done) nn_q  <= nn_sel;
                DIV_TNA: if (div_done) tna_q <= tna_sel;
                DIV_T0:  if (div_done) t0_q  <= quo_w;
                DIV_DLT: if (div_done) dlt_q <= quo_w;
                STORE: begin
                    nn_r[ax_q*W +: W]  <= fin_nn;
                    t0_r[ax_q*W +: W]  <= fin_t0;
                    tna_r[ax_q*W +: W] <= fin_tna;
                    dl_r[ax_q*W +: W]  <= out_dl;
`ifdef CALC_CLAMP_EN
                    sat_q[ax_q]        <= clamp;
`endif
                    ax_q               <= ax_q + AXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign nn_o    = nn_r;
    assign t0_o    = t0_r;
    assign tna_o   = tna_r;
    assign delta_o = dl_r;

endmodule

// File: tb/tb_calc_profile_params_multi.sv
// tb_calc_profile_params_multi
//   Directed scoreboard bench: each accepted request pushes its hand-computed
//   expected results; a monitor pops and compares on every done pulse.
module tb_calc_profile_params_multi;

    localparam int NA  = 4;
    localparam int W   = 32;
    localparam int TW  = 64;
    localparam int LAT = 2 + NA * (4 * (TW + 2) + 1);

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [NA*W-1:0] steps = '0;
    logic [W-1:0] max_n = '0, max_nn = '0, max_tna = '0, max_delta = '0;
    logic [TW-1:0] t1 = '0, t2 = '0, tt = '0;
    logic busy, done;
    logic [NA*W-1:0] nn_o, t0_o, tna_o, delta_o;
    logic [NA-1:0] sat;

    calc_profile_params_multi #(.NUM_AXES(NA), .W(W), .TW(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .steps(steps),
        .max_n(max_n), .max_nn(max_nn), .max_tna(max_tna), .max_delta(max_delta),
        .t1(t1), .t2(t2), .tt(tt), .busy(busy), .done(done),
        .nn_o(nn_o), .t0_o(t0_o), .tna_o(tna_o), .delta_o(delta_o), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NA*W-1:0] nn, t0, tna, dl;
        logic [NA-1:0]   sat;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    exp_t mon_e;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic set_lim(input int unsigned nmax, nnmax, t1v, t2v, ttv, mtna, mdl);
        max_n = nmax; max_nn = nnmax; t1 = TW'(t1v); t2 = TW'(t2v); tt = TW'(ttv);
        max_tna = mtna; max_delta = mdl;
    endtask

    task automatic set_steps(input int unsigned s0, s1, s2, s3);
        steps = {W'(s3), W'(s2), W'(s1), W'(s0)};
    endtask

    task automatic clr_exp();
        cur.nn = '0; cur.t0 = '0; cur.tna = '0; cur.dl = '0; cur.sat = '0;
    endtask

    // Expected raw values per axis; the clamp build derives the clamped view.
    task automatic set_ax(input int a, input int unsigned nn, t0, tna, dl);
        cur.nn[a*W +: W]  = nn;
        cur.t0[a*W +: W]  = t0;
        cur.tna[a*W +: W] = tna;
        cur.dl[a*W +: W]  = dl;
`ifdef CALC_CLAMP_EN
        if (dl > max_delta) begin
            cur.dl[a*W +: W] = max_delta;
            cur.sat[a] = 1'b1;
        end
`endif
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the accepting edge to done; optionally fires an
    // extra start with different steps at cycle ms (0 = none).
    task automatic wait_done(input string nm, input int ms);
        int  n = 0;
        bit  seen = 0;
        bit  busy_ok = 1;
        while (!seen && n < 2 * LAT) begin
            @(negedge clk);
            n++;
            if (ms != 0 && n == ms) begin
                set_steps(7, 7, 7, 7);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        chk({nm, " latency"}, 64'(n), 64'(LAT));
        chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (expq.size() == 0) begin
                chk("spurious done", 64'd1, 64'd0);
            end else begin
                mon_e = expq.pop_front();
                for (int a = 0; a < NA; a++) begin
                    chk($sformatf("ax%0d nn", a),    64'(nn_o[a*W +: W]),    64'(mon_e.nn[a*W +: W]));
                    chk($sformatf("ax%0d t0", a),    64'(t0_o[a*W +: W]),    64'(mon_e.t0[a*W +: W]));
                    chk($sformatf("ax%0d tna", a),   64'(tna_o[a*W +: W]),   64'(mon_e.tna[a*W +: W]));
                    chk($sformatf("ax%0d delta", a), 64'(delta_o[a*W +: W]), 64'(mon_e.dl[a*W +: W]));
                end
                chk("sat", 64'(sat), 64'(mon_e.sat));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset nn", 64'(nn_o[63:0]), 64'd0);
        chk("reset delta", 64'(delta_o[63:0]), 64'd0);
        chk("reset sat", 64'(sat), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // T1: FULL, axis0 N=500
        set_lim(1000, 100, 20000, 50000, 300, 100, 5);
        set_steps(500, 0, 0, 0);
        clr_exp(); set_ax(0, 50, 664, 125, 10);
        expq.push_back(cur);
        launch(); wait_done("T1", 0);

        // T2: FULL, N = 0,1,2,3
        set_steps(0, 1, 2, 3);
        clr_exp();
        set_ax(1, 1, 300, 100, 5);
        set_ax(2, 1, 150, 100, 0);
        set_ax(3, 1, 20000, 50000, 0);
        expq.push_back(cur);
        launch(); wait_done("T2", 0);

        // T3: SHORT, N = 10,3,2,1
        set_lim(100, 60, 20000, 50000, 300, 100, 5);
        set_steps(10, 3, 2, 1);
        clr_exp();
        set_ax(0, 5, 133, 100, 6);
        set_ax(1, 1, 600, 100, 500);
        set_ax(2, 1, 600, 100, 0);
        set_ax(3, 1, 300, 100, 5);
        expq.push_back(cur);
        launch(); wait_done("T3", 0);

        // Mode boundary: Nmax == 2*NNmax+2 is FULL
        set_lim(122, 60, 20000, 400, 300, 100, 5);
        set_steps(10, 0, 0, 0);
        clr_exp(); set_ax(0, 4, 7880, 200, 1920);
        expq.push_back(cur);
        launch(); wait_done("edge full", 0);

        // One below the boundary is SHORT
        set_lim(121, 60, 20000, 400, 300, 100, 5);
        clr_exp(); set_ax(0, 5, 133, 100, 6);
        expq.push_back(cur);
        launch(); wait_done("edge short", 0);

        // T4: second start mid-run must be ignored
        set_lim(1000, 100, 20000, 50000, 300, 100, 5);
        set_steps(500, 0, 0, 0);
        clr_exp(); set_ax(0, 50, 664, 125, 10);
        expq.push_back(cur);
        launch(); wait_done("T4", 300);
        repeat (LAT + 20) @(negedge clk);

        // T5: reset in the middle of axis 2, then a clean run
        set_lim(1000, 100, 20000, 50000, 300, 100, 5);
        set_steps(0, 1, 2, 3);
        launch();
        repeat (2 + 2 * (4 * (TW + 2) + 1) + 30) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("T5 busy", 64'(busy), 64'd0);
        chk("T5 done", 64'(done), 64'd0);
        chk("T5 nn", 64'(nn_o[63:0]), 64'd0);
        chk("T5 t0", 64'(t0_o[63:0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        clr_exp();
        set_ax(1, 1, 300, 100, 5);
        set_ax(2, 1, 150, 100, 0);
        set_ax(3, 1, 20000, 50000, 0);
        expq.push_back(cur);
        launch(); wait_done("T5", 0);

        repeat (5) @(negedge clk);
        chk("queue empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
